boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: BASE_ADDR, 16'hFF00, first memory address written by the image.
REQ-002 Parameter: IMAGE_LEN, 256, number of image bytes before the checksum byte; legal range 1..65536.
REQ-003 Port: ph1  input  1  the single block clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream byte source presents a byte.
REQ-006 Port: in_data  input  8  image or checksum byte.
REQ-007 Port: in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
REQ-008 Port: mem_address  output  16  write address to the memory stage.
REQ-009 Port: mem_data  output  8  write data to the memory stage.
REQ-010 Port: mem_write_en  output  1  one-cycle write strobe to the memory stage.
REQ-011 Port: cpu_reset  output  1  reset to the CPU; high until the image is loaded and verified.
REQ-012 Port: load_done  output  1  image loaded, checksum good, CPU released.
REQ-013 Port: load_error  output  1  checksum mismatch; CPU held in reset.

Function
REQ-014 The block SHALL be a state machine with states LOAD, CHECK, RUN and ERROR.
REQ-015 In LOAD, in_ready SHALL be 1; each accepted byte SHALL add to an 8-bit running sum (mod 256) and increment a 17-bit byte count.
REQ-016 An accepted image byte k (0-based) SHALL produce, on the next cycle only, mem_write_en=1, mem_address=(BASE_ADDR+k) mod 2^16, mem_data=that byte.
REQ-017 Address arithmetic SHALL wrap from 16'hFFFF to 16'h0000 without error.
REQ-018 On the cycle the IMAGE_LEN-th byte is accepted, the state SHALL become CHECK.
REQ-019 In CHECK, in_ready SHALL be 1; the accepted byte SHALL NOT be written to memory (mem_write_en stays 0 for it).
REQ-020 In CHECK, if (sum + byte) mod 256 == 0, the next state SHALL be RUN; otherwise ERROR.
REQ-021 In RUN: in_ready=0, cpu_reset=0, load_done=1, load_error=0; RUN SHALL persist until reset.
REQ-022 In ERROR: in_ready=0, cpu_reset=1, load_done=0, load_error=1; ERROR SHALL persist until reset.
REQ-023 cpu_reset SHALL be 1 in LOAD and CHECK, and SHALL fall on the same edge on which the state enters RUN.
REQ-024 in_valid while in_ready=0 SHALL be ignored, with no state, sum, count or memory effect.
REQ-025 Cycles with in_valid=0 in LOAD/CHECK SHALL hold all state; gaps between bytes of any length are legal.
REQ-026 mem_write_en SHALL be 0 whenever no image byte was accepted on the previous cycle.
REQ-027 in_ready SHALL be a pure function of state (no combinational path from in_valid or in_data).

Reset
REQ-028 reset SHALL take priority over every other event, including a byte transfer in the same cycle.
REQ-029 After reset: state=LOAD, count=0, sum=0, in_ready=1, cpu_reset=1, mem_write_en=0, mem_address=BASE_ADDR, mem_data=0, load_done=0, load_error=0.
REQ-030 Reset mid-load, in CHECK, RUN or ERROR SHALL restart loading from BASE_ADDR; previously written memory is not cleared.

Structure
REQ-031 The state enum typedef and default BASE_ADDR/IMAGE_LEN constants SHALL live in a shared package, hmc_boot_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; mem_* outputs SHALL be registered.

Verification
REQ-033 IMAGE_LEN=4, BASE_ADDR=16'hFFFE, bytes 01,02,03,04, checksum F6 -> writes FFFE=01, FFFF=02, 0000=03, 0001=04; RUN; cpu_reset falls; load_done=1.
REQ-034 IMAGE_LEN=4, bytes 01,02,03,04, checksum F7 -> four writes; ERROR; load_error=1; cpu_reset stays 1; further in_valid has no effect.
REQ-035 in_valid toggled 1,0,0,1,... across the load -> write addresses contiguous; no write on idle cycles; final state matches REQ-033.
REQ-036 reset asserted after the 2nd of 4 bytes, coincident with a transfer -> that byte not written; reload of 4 bytes from BASE_ADDR and correct checksum reaches RUN.
REQ-037 Default parameters, 256 bytes of 00 then checksum 00 -> 256 writes FF00..FFFF; RUN; then in_valid=1 with in_data=AA -> in_ready=0, no write.

Source files
------------

// File: rtl/hmc_boot_pkg.sv
// hmc_boot_pkg: shared loader state encoding and default image placement.
package hmc_boot_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [15:0] DEF_BASE_ADDR = 16'hFF00;
    localparam int          DEF_IMAGE_LEN = 256;

endpackage

// File: rtl/boot_loader.sv
// boot_loader: streams an image into memory, verifies its checksum and releases the CPU.
module boot_loader
    import hmc_boot_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          IMAGE_LEN = DEF_IMAGE_LEN
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_write_en,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam logic [16:0] LAST_IDX = 17'(IMAGE_LEN - 1);

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_count;
    logic [7:0]  r_sum;
    logic        w_take;
    logic        w_write;
    logic        w_sum_ok;

    always_comb begin
        in_ready   = (r_state == ST_LOAD) || (r_state == ST_CHECK);
        cpu_reset  = r_state != ST_RUN;
        load_done  = r_state == ST_RUN;
        load_error = r_state == ST_ERROR;
        w_take     = in_valid && in_ready;
        w_write    = w_take && (r_state == ST_LOAD);
        w_sum_ok   = 8'(r_sum + in_data) == 8'h00;
        w_next     = r_state;
        if (w_write && r_count == LAST_IDX)
            w_next = ST_CHECK;
        else if (w_take && r_state == ST_CHECK)
            w_next = w_sum_ok ? ST_RUN : ST_ERROR;
    end

    // Address is taken from the pre-increment count, so the 16-bit add wraps naturally.
    always_ff @(posedge ph1) begin
        if (reset) begin
            r_state      <= ST_LOAD;
            r_count      <= '0;
            r_sum        <= '0;
            mem_write_en <= 1'b0;
            mem_address  <= BASE_ADDR;
            mem_data     <= '0;
        end else begin
            r_state      <= w_next;
            mem_write_en <= w_write;
            if (w_write) begin
                r_count     <= r_count + 17'd1;
                r_sum       <= r_sum + in_data;
                mem_address <= BASE_ADDR + r_count[15:0];
                mem_data    <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench driving a 4-byte wrapping instance and a default instance.
module tb_boot_loader;

    logic        ph1 = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic        vld = 1'b0;
    logic [7:0]  dat = 8'h00;
    logic        rdy [2];
    logic [15:0] addr [2];
    logic [7:0]  mdat [2];
    logic        we [2];
    logic        cpu_rst [2];
    logic        done [2];
    logic        err [2];

    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    int          m_k [2];
    logic [7:0]  m_sum [2];
    int          m_st [2];

    always #5 ph1 = ~ph1;

    boot_loader #(.BASE_ADDR(16'hFFFE), .IMAGE_LEN(4)) u_a (
        .ph1(ph1), .reset(rst[0]), .in_valid(vld), .in_data(dat), .in_ready(rdy[0]),
        .mem_address(addr[0]), .mem_data(mdat[0]), .mem_write_en(we[0]),
        .cpu_reset(cpu_rst[0]), .load_done(done[0]), .load_error(err[0])
    );

    boot_loader u_b (
        .ph1(ph1), .reset(rst[1]), .in_valid(vld), .in_data(dat), .in_ready(rdy[1]),
        .mem_address(addr[1]), .mem_data(mdat[1]), .mem_write_en(we[1]),
        .cpu_reset(cpu_rst[1]), .load_done(done[1]), .load_error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input logic v, input logic [7:0] d, input logic r);
        logic [15:0] base;
        int          len;
        base = (i == 0) ? 16'hFFFE : 16'hFF00;
        len  = (i == 0) ? 4 : 256;
        if (r) begin
            m_k[i] = 0;
            m_sum[i] = 8'h00;
            m_st[i] = 0;
        end else if (v && m_st[i] == 0) begin
            if (i == 0) q0.push_back({16'(base + 16'(m_k[i])), d});
            else        q1.push_back({16'(base + 16'(m_k[i])), d});
            m_sum[i] = m_sum[i] + d;
            m_k[i]++;
            if (m_k[i] == len) m_st[i] = 1;
        end else if (v && m_st[i] == 1) begin
            m_st[i] = (8'(m_sum[i] + d) == 8'h00) ? 2 : 3;
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] r);
        @(negedge ph1);
        if (chk_en)
            for (int i = 0; i < 2; i++)
                check(i == 0 ? "status_a" : "status_b",
                      {28'd0, rdy[i], cpu_rst[i], done[i], err[i]},
                      {28'd0, m_st[i] < 2, m_st[i] != 2, m_st[i] == 2, m_st[i] == 3});
        vld = v;
        dat = d;
        rst = r;
        for (int i = 0; i < 2; i++) model_step(i, v, d, r[i]);
    endtask

    always @(posedge ph1) begin
        logic [23:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (we[i] === 1'b1) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    check(i == 0 ? "spurious_we_a" : "spurious_we_b", 32'd1, 32'd0);
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check(i == 0 ? "write_a" : "write_b", {8'd0, addr[i], mdat[i]}, {8'd0, e});
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] d);
        cycle(1'b1, d, 2'b10);
    endtask

    task automatic reset_a;
        cycle(1'b0, 8'h00, 2'b11);
        cycle(1'b0, 8'h00, 2'b10);
    endtask

    initial begin
        logic [7:0] img [4];
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        cycle(1'b0, 8'h00, 2'b11);
        cycle(1'b0, 8'h00, 2'b11);
        chk_en = 1'b1;
        @(negedge ph1);
        check("rst_addr_a", {16'd0, addr[0]}, 32'h0000FFFE);
        check("rst_addr_b", {16'd0, addr[1]}, 32'h0000FF00);
        check("rst_data_we", {23'd0, mdat[0], we[0]}, 32'd0);
        check("rst_status", {28'd0, rdy[0], cpu_rst[0], done[0], err[0]}, 32'b1100);
        // wrapping load with good checksum
        cycle(1'b0, 8'h00, 2'b10);
        foreach (img[j]) send_a(img[j]);
        send_a(8'hF6);
        repeat (3) cycle(1'b0, 8'h00, 2'b10);
        check("run_done_a", {30'd0, done[0], cpu_rst[0]}, 32'b10);
        // bad checksum, then traffic that must be ignored
        reset_a();
        foreach (img[j]) send_a(img[j]);
        send_a(8'hF7);
        repeat (4) send_a(8'hAA);
        cycle(1'b0, 8'h00, 2'b10);
        check("error_a", {30'd0, err[0], cpu_rst[0]}, 32'b11);
        // sparse valid: 1,0,0 pattern
        reset_a();
        foreach (img[j]) begin
            send_a(img[j]);
            repeat (2) cycle(1'b0, 8'h55, 2'b10);
        end
        send_a(8'hF6);
        repeat (2) cycle(1'b0, 8'h00, 2'b10);
        check("sparse_done_a", {31'd0, done[0]}, 32'd1);
        // reset coincident with the third transfer, then a full reload
        reset_a();
        send_a(8'h01);
        send_a(8'h02);
        cycle(1'b1, 8'h03, 2'b11);
        cycle(1'b0, 8'h00, 2'b10);
        check("reload_addr_a", {16'd0, addr[0]}, 32'h0000FFFE);
        foreach (img[j]) send_a(img[j]);
        send_a(8'hF6);
        repeat (2) cycle(1'b0, 8'h00, 2'b10);
        check("reload_done_a", {31'd0, done[0]}, 32'd1);
        // default instance: 256 zero bytes and zero checksum
        cycle(1'b0, 8'h00, 2'b11);
        cycle(1'b0, 8'h00, 2'b01);
        for (int j = 0; j < 256; j++) cycle(1'b1, 8'h00, 2'b01);
        cycle(1'b1, 8'h00, 2'b01);
        repeat (3) cycle(1'b1, 8'hAA, 2'b01);
        cycle(1'b0, 8'h00, 2'b01);
        check("default_done_b", {30'd0, done[1], rdy[1]}, 32'b10);
        check("queue_a_drained", q0.size(), 32'd0);
        check("queue_b_drained", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
